// File: rtl/datapath.sv
// Mini SRC single-bus 32-bit datapath: register file, special registers, ALU,
// select/encode logic and a 512-word internal RAM, all steered by external controls.
module datapath #(
    parameter int unsigned RAM_DEPTH = 512
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        incPC,
    input  logic        e_PC,
    input  logic        e_IR,
    input  logic        e_Y,
    input  logic        e_Z,
    input  logic        e_HI,
    input  logic        e_LO,
    input  logic        e_MAR,
    input  logic        e_MDR,
    input  logic        e_GP,
    input  logic        e_OutPort,
    input  logic        e_InPort,
    input  logic        ram_read,
    input  logic        ram_write,
    input  logic [31:0] Mdatain,
    input  logic        MDR_read,
    input  logic [3:0]  ALU_op,
    input  logic [4:0]  BusDataSelect,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        e_Rin,
    input  logic        e_Rout,
    input  logic        BAout,
    input  logic        imm_sel,
    input  logic [31:0] in_port_data,
    output logic [31:0] out_port_data
);

    localparam int unsigned W  = 32;
    localparam int unsigned AW = $clog2(RAM_DEPTH);

    logic [W-1:0] gpr [16];
    logic [W-1:0] pc, ir, y, z_hi, z_lo, hi, lo, mar, mdr, in_port;
    logic [W-1:0] ram [RAM_DEPTH];

    logic [W-1:0]   bus, imm_sext, sel_val, alu_b, ram_rdata, mdr_in;
    logic [3:0]     gp_idx;
    logic [2*W-1:0] alu_res;
    logic           unused_bits;

    assign imm_sext    = {{13{ir[18]}}, ir[18:0]};
    assign ram_rdata   = ram[mar[AW-1:0]];
    assign mdr_in      = MDR_read ? (ram_read ? ram_rdata : Mdatain) : bus;
    assign alu_b       = imm_sel ? imm_sext : bus;
    assign unused_bits = ^{mar[W-1:AW], ir[W-1:27]};

    // Select/encode: Gra > Grb > Grc, BAout turns an R0 read into constant 0
    always_comb begin
        gp_idx = 4'd0;
        if (Gra)      gp_idx = ir[26:23];
        else if (Grb) gp_idx = ir[22:19];
        else if (Grc) gp_idx = ir[18:15];
        sel_val = (BAout && gp_idx == 4'd0) ? '0 : gpr[gp_idx];
    end

    always_comb begin
        bus = '0;
        if (e_Rout || BAout) begin
            bus = sel_val;
        end else if (!BusDataSelect[4]) begin
            bus = gpr[BusDataSelect[3:0]];
        end else begin
            case (BusDataSelect[3:0])
                4'd0:    bus = hi;
                4'd1:    bus = lo;
                4'd2:    bus = z_hi;
                4'd3:    bus = z_lo;
                4'd4:    bus = pc;
                4'd5:    bus = mdr;
                4'd6:    bus = in_port;
                4'd7:    bus = imm_sext;
                default: bus = '0;
            endcase
        end
    end

    // ALU: A is always Y; result is {Zhigh, Zlow}
    logic signed [2*W-1:0] prod;
    logic [2*W-1:0]        rot_r, rot_l;
    logic [W-1:0]          quot, rem;
    logic [4:0]            sh;

    always_comb begin
        sh      = alu_b[4:0];
        prod    = $signed({{W{y[W-1]}}, y}) * $signed({{W{alu_b[W-1]}}, alu_b});
        rot_r   = {y, y} >> sh;
        rot_l   = {y, y} << sh;
        quot    = $signed(y) / $signed(alu_b);
        rem     = $signed(y) % $signed(alu_b);
        alu_res = '0;
        case (ALU_op)
            4'd0:    alu_res = {32'h0, y + alu_b};
            4'd1:    alu_res = {32'h0, y - alu_b};
            4'd2:    alu_res = {32'h0, y & alu_b};
            4'd3:    alu_res = {32'h0, y | alu_b};
            4'd4:    alu_res = {32'h0, y >> sh};
            4'd5:    alu_res = {32'h0, W'($signed(y) >>> sh)};
            4'd6:    alu_res = {32'h0, y << sh};
            4'd7:    alu_res = {32'h0, rot_r[W-1:0]};
            4'd8:    alu_res = {32'h0, rot_l[2*W-1:W]};
            4'd9:    alu_res = prod;
            4'd10:   alu_res = (alu_b == '0) ? {y, 32'hFFFF_FFFF} : {rem, quot};
            4'd11:   alu_res = {32'h0, W'(32'd0 - alu_b)};
            4'd12:   alu_res = {32'h0, ~alu_b};
            4'd13:   alu_res = {32'h0, alu_b};
            default: alu_res = '0;
        endcase
        if (incPC) alu_res = {32'h0, alu_b + 32'd1};
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) gpr[i] <= '0;
            pc            <= '0;
            ir            <= '0;
            y             <= '0;
            z_hi          <= '0;
            z_lo          <= '0;
            hi            <= '0;
            lo            <= '0;
            mar           <= '0;
            mdr           <= '0;
            in_port       <= '0;
            out_port_data <= '0;
        end else begin
            if (e_GP && e_Rin) gpr[gp_idx] <= bus;
            if (e_PC)          pc <= bus;
            else if (incPC)    pc <= pc + 32'd1;
            if (e_IR)          ir <= bus;
            if (e_Y)           y <= bus;
            if (e_Z)           {z_hi, z_lo} <= alu_res;
            if (e_HI)          hi <= bus;
            if (e_LO)          lo <= bus;
            if (e_MAR)         mar <= bus;
            if (e_MDR)         mdr <= mdr_in;
            if (e_InPort)      in_port <= in_port_data;
            if (e_OutPort)     out_port_data <= bus;
        end
    end

    // RAM is not cleared by reset
    always_ff @(posedge clock) begin
        if (ram_write) ram[mar[AW-1:0]] <= mdr;
    end

endmodule

// File: tb/tb_datapath.sv
// Directed and randomized checks of the Mini SRC datapath; all state is observed
// by routing it over the bus into the output port.
module tb_datapath;

    logic        clock = 1'b0;
    logic        clear;
    logic        incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MAR, e_MDR, e_GP;
    logic        e_OutPort, e_InPort, ram_read, ram_write, MDR_read;
    logic [31:0] Mdatain, in_port_data, out_port_data;
    logic [3:0]  ALU_op;
    logic [4:0]  BusDataSelect;
    logic        Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel;

    int n_checks = 0;
    int n_fail   = 0;

    datapath dut (
        .clock(clock), .clear(clear), .incPC(incPC), .e_PC(e_PC), .e_IR(e_IR),
        .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI), .e_LO(e_LO), .e_MAR(e_MAR),
        .e_MDR(e_MDR), .e_GP(e_GP), .e_OutPort(e_OutPort), .e_InPort(e_InPort),
        .ram_read(ram_read), .ram_write(ram_write), .Mdatain(Mdatain),
        .MDR_read(MDR_read), .ALU_op(ALU_op), .BusDataSelect(BusDataSelect),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .e_Rin(e_Rin), .e_Rout(e_Rout),
        .BAout(BAout), .imm_sel(imm_sel), .in_port_data(in_port_data),
        .out_port_data(out_port_data)
    );

    always #5 clock = ~clock;

    task automatic idle();
        incPC = 0; e_PC = 0; e_IR = 0; e_Y = 0; e_Z = 0; e_HI = 0; e_LO = 0;
        e_MAR = 0; e_MDR = 0; e_GP = 0; e_OutPort = 0; e_InPort = 0;
        ram_read = 0; ram_write = 0; MDR_read = 0; ALU_op = 4'd0;
        BusDataSelect = 5'd0; Gra = 0; Grb = 0; Grc = 0; e_Rin = 0;
        e_Rout = 0; BAout = 0; imm_sel = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Load InPort with v and leave it selected on the bus for the next tick
    task automatic drive_in(input logic [31:0] v);
        in_port_data = v;
        e_InPort = 1;
        tick();
        BusDataSelect = 5'd22;
    endtask

    task automatic observe(input logic [4:0] src, output logic [31:0] v);
        BusDataSelect = src;
        e_OutPort = 1;
        tick();
        v = out_port_data;
    endtask

    task automatic write_gp(input logic [3:0] k, input logic [31:0] v);
        drive_in({5'd0, k, 23'd0}); e_IR = 1; tick();
        drive_in(v); Gra = 1; e_Rin = 1; e_GP = 1; tick();
    endtask

    task automatic alu_run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic inc, output logic [63:0] z);
        logic [31:0] zl, zh;
        drive_in(a); e_Y = 1; tick();
        drive_in(b); ALU_op = op; incPC = inc; e_Z = 1; tick();
        observe(5'd19, zl);
        observe(5'd18, zh);
        z = {zh, zl};
    endtask

    function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic inc);
        longint sa, sb, q, r;
        logic [31:0] x;
        int s;
        sa = $signed(a);
        sb = $signed(b);
        s  = int'(b[4:0]);
        x  = a;
        if (inc) return {32'h0, b + 32'd1};
        case (op)
            4'd0:  return {32'h0, a + b};
            4'd1:  return {32'h0, a - b};
            4'd2:  return {32'h0, a & b};
            4'd3:  return {32'h0, a | b};
            4'd4:  return {32'h0, a >> s};
            4'd5:  begin x = 32'(sa >>> s); return {32'h0, x}; end
            4'd6:  return {32'h0, a << s};
            4'd7:  begin for (int i = 0; i < s; i++) x = {x[0], x[31:1]}; return {32'h0, x}; end
            4'd8:  begin for (int i = 0; i < s; i++) x = {x[30:0], x[31]}; return {32'h0, x}; end
            4'd9:  return 64'(sa * sb);
            4'd10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
            4'd11: return {32'h0, 32'h0 - b};
            4'd12: return {32'h0, ~b};
            4'd13: return {32'h0, b};
            default: return 64'h0;
        endcase
    endfunction

    logic [31:0] v;
    logic [63:0] z, ez;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        inc;
    logic [8:0]  addr_q [8];
    logic [31:0] data_q [8];

    initial begin
        idle();
        Mdatain = '0;
        in_port_data = '0;
        clear = 1;
        #2;
        check("reset_out", out_port_data, 32'h0);
        #10;
        clear = 0;

        // Register write and readback, R0 writable
        write_gp(4'd3, 32'h1234_5678);
        observe(5'd3, v);  check("r3_write", v, 32'h1234_5678);
        write_gp(4'd0, 32'h0000_0055);
        observe(5'd0, v);  check("r0_write", v, 32'h0000_0055);

        // Fetch: preload RAM[0], then T0..T2
        drive_in(32'h0);          e_MAR = 1; tick();
        drive_in(32'h0980_0000);  e_MDR = 1; tick();
        ram_write = 1; tick();
        drive_in(32'h0);          e_MDR = 1; tick();
        drive_in(32'h0);          e_PC = 1; tick();
        BusDataSelect = 5'd20; e_MAR = 1; e_Z = 1; incPC = 1; tick();
        observe(5'd19, v); check("t0_zlow", v, 32'h1);
        BusDataSelect = 5'd19; e_PC = 1; MDR_read = 1; ram_read = 1; e_MDR = 1; tick();
        observe(5'd20, v); check("t1_pc", v, 32'h1);
        observe(5'd21, v); check("t1_mdr", v, 32'h0980_0000);
        BusDataSelect = 5'd21; e_IR = 1; tick();

        // OUT R3 via IR[26:23]=3
        Gra = 1; e_Rout = 1; e_OutPort = 1; tick();
        check("out_r3", out_port_data, 32'h1234_5678);

        // IN R3
        in_port_data = 32'hBEEF_1234; e_InPort = 1; tick();
        BusDataSelect = 5'd22; Gra = 1; e_Rin = 1; e_GP = 1; tick();
        observe(5'd3, v); check("in_r3", v, 32'hBEEF_1234);

        // BAout with index 0 reads 0 even though R0 holds 0x55
        observe(5'd25, v); check("sel_25_zero", v, 32'h0);
        drive_in(32'h0); e_IR = 1; tick();
        observe(5'd0, v);  check("r0_kept", v, 32'h55);
        BAout = 1; e_OutPort = 1; tick();
        check("baout_r0", out_port_data, 32'h0);
        observe(5'd0, v);
        Gra = 1; e_Rout = 1; e_OutPort = 1; tick();
        check("rout_r0", out_port_data, 32'h55);

        // Directed ALU points
        alu_run(4'd0, 32'd7, 32'd3, 1'b0, z);  check("add", z[31:0], 32'd10);
        alu_run(4'd1, 32'd7, 32'd3, 1'b0, z);  check("sub", z[31:0], 32'd4);
        check("sub_hi", z[63:32], 32'h0);
        alu_run(4'd9, 32'hFFFF_FFFF, 32'd2, 1'b0, z);
        check("mul_lo", z[31:0], 32'hFFFF_FFFE);
        check("mul_hi", z[63:32], 32'hFFFF_FFFF);
        alu_run(4'd10, 32'd7, 32'd2, 1'b0, z);
        check("div_q", z[31:0], 32'd3);
        check("div_r", z[63:32], 32'd1);
        alu_run(4'd10, 32'h0000_0123, 32'd0, 1'b0, z);
        check("div0_lo", z[31:0], 32'hFFFF_FFFF);
        check("div0_hi", z[63:32], 32'h0000_0123);
        alu_run(4'd14, 32'd9, 32'd9, 1'b1, z);
        check("incpc_b1", z[31:0], 32'd10);

        // Immediate operand: IR[18:0] sign-extended
        drive_in(32'h0004_0005); e_IR = 1; tick();
        observe(5'd23, v); check("imm_bus", v, 32'hFFFC_0005);
        drive_in(32'd1); e_Y = 1; tick();
        drive_in(32'h0000_0777); imm_sel = 1; ALU_op = 4'd0; e_Z = 1; tick();
        observe(5'd19, v); check("imm_add", v, 32'hFFFC_0006);

        // Random ALU against the reference model
        for (int i = 0; i < 40; i++) begin
            op  = 4'($urandom_range(0, 15));
            a   = $urandom;
            b   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            inc = ($urandom_range(0, 7) == 0);
            if (op == 4'd10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            alu_run(op, a, b, inc, z);
            ez = alu_ref(op, a, b, inc);
            check($sformatf("alu_rand_lo op=%0d a=%h b=%h inc=%0d", op, a, b, inc), z[31:0], ez[31:0]);
            check($sformatf("alu_rand_hi op=%0d a=%h b=%h inc=%0d", op, a, b, inc), z[63:32], ez[63:32]);
        end

        // PC priority: load beats increment
        drive_in(32'd50); e_PC = 1; incPC = 1; tick();
        observe(5'd20, v); check("pc_load_prio", v, 32'd50);
        incPC = 1; tick();
        observe(5'd20, v); check("pc_inc", v, 32'd51);

        // Multiple destinations from one bus value
        drive_in(32'hA5A5_0F0F); e_HI = 1; e_LO = 1; e_Y = 1; tick();
        observe(5'd16, v); check("hi_load", v, 32'hA5A5_0F0F);
        observe(5'd17, v); check("lo_load", v, 32'hA5A5_0F0F);

        // Memory write then read back
        drive_in(32'd5); e_MAR = 1; tick();
        drive_in(32'hCAFE_F00D); e_MDR = 1; tick();
        ram_write = 1; tick();
        drive_in(32'h0); e_MDR = 1; tick();
        MDR_read = 1; ram_read = 1; e_MDR = 1; tick();
        observe(5'd21, v); check("ram5_read", v, 32'hCAFE_F00D);

        // Write and read the same word in one cycle: MDR sees the old word
        drive_in(32'h1111_1111); e_MDR = 1; tick();
        ram_write = 1; MDR_read = 1; ram_read = 1; e_MDR = 1; tick();
        observe(5'd21, v); check("ram_rw_old", v, 32'hCAFE_F00D);
        MDR_read = 1; ram_read = 1; e_MDR = 1; tick();
        observe(5'd21, v); check("ram_rw_new", v, 32'h1111_1111);

        // External memory data path
        Mdatain = 32'h0BAD_BEEF; MDR_read = 1; e_MDR = 1; tick();
        observe(5'd21, v); check("mdatain", v, 32'h0BAD_BEEF);

        // Random RAM traffic
        for (int i = 0; i < 8; i++) begin
            addr_q[i] = 9'(i * 60 + $urandom_range(0, 50));
            data_q[i] = $urandom;
            drive_in({23'h0, addr_q[i]}); e_MAR = 1; tick();
            drive_in(data_q[i]); e_MDR = 1; tick();
            ram_write = 1; tick();
        end
        for (int i = 7; i >= 0; i--) begin
            drive_in({23'h0, addr_q[i]}); e_MAR = 1; tick();
            MDR_read = 1; ram_read = 1; e_MDR = 1; tick();
            observe(5'd21, v);
            check($sformatf("ram_rand addr=%0d", addr_q[i]), v, data_q[i]);
        end

        // Asynchronous clear mid-run
        write_gp(4'd9, 32'h9999_0001);
        observe(5'd9, v); check("pre_clear", v, 32'h9999_0001);
        #2;
        clear = 1;
        #2;
        check("clear_async_out", out_port_data, 32'h0);
        clear = 0;
        #1;
        for (int k = 0; k < 16; k++) begin
            observe(5'(k), v); check($sformatf("clear_r%0d", k), v, 32'h0);
        end
        for (int s = 16; s < 24; s++) begin
            observe(5'(s), v); check($sformatf("clear_src%0d", s), v, 32'h0);
        end
        BusDataSelect = 5'd24; ALU_op = 4'd0; e_Z = 1; tick();
        observe(5'd19, v); check("clear_y", v, 32'h0);
        MDR_read = 1; ram_read = 1; e_MDR = 1; tick();
        observe(5'd21, v); check("clear_mar_ram0", v, 32'h0980_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
